// File: rtl/cordic_gain_comp.sv
// Pipelined CORDIC gain compensation: x/y * COEF (Q1.(COEF_WIDTH-1)) with round/saturate, bypass and valid/ready stall.
// Optional macro CGC_ROUND_EN selects round-half-up; the default build truncates toward -inf.
module cordic_gain_comp #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int COEF       = 19898
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  sat
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic signed [COEF_WIDTH-1:0] COEF_C = COEF_WIDTH'(COEF);
`ifdef CGC_ROUND_EN
  localparam logic signed [PW:0] RND = (PW+1)'(1) << (COEF_WIDTH-2);
`else
  localparam logic signed [PW:0] RND = '0;
`endif
  localparam logic signed [DATA_WIDTH:0] MAX_P = (DATA_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [DATA_WIDTH:0] MIN_N = (DATA_WIDTH+1)'(-(1 << (DATA_WIDTH-1)));

  // Handshake: a stage moves only when the output register is empty or being
  // drained this cycle (adv); in_valid & in_ready on a rising edge accepts a sample.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic                         s1_valid, s1_byp;
  logic signed [DATA_WIDTH-1:0] s1_x, s1_y;
  logic                         s2_valid, s2_byp;
  logic signed [DATA_WIDTH-1:0] s2_x, s2_y;
  logic signed [PW-1:0]         s2_px, s2_py;

  logic signed [PW-1:0]  mul_x, mul_y;
  logic [DATA_WIDTH:0]   sc_x, sc_y;

  assign mul_x = PW'(s1_x) * PW'(COEF_C);
  assign mul_y = PW'(s1_y) * PW'(COEF_C);

  // Returns {saturated, value}; the shifted result keeps one guard bit so the
  // single overflow case (min * min) is still detected.
  function automatic logic [DATA_WIDTH:0] scale(input logic signed [PW-1:0] p);
    logic signed [PW:0]         sum;
    logic signed [DATA_WIDTH:0] r;
    sum = (PW+1)'(p) + RND;
    r   = (DATA_WIDTH+1)'(sum >>> (COEF_WIDTH-1));
    if (r > MAX_P)      scale = {1'b1, MAX_P[DATA_WIDTH-1:0]};
    else if (r < MIN_N) scale = {1'b1, MIN_N[DATA_WIDTH-1:0]};
    else                scale = {1'b0, r[DATA_WIDTH-1:0]};
  endfunction

  assign sc_x = scale(s2_px);
  assign sc_y = scale(s2_py);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_byp    <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      s2_byp    <= 1'b0;
      s2_x      <= '0;
      s2_y      <= '0;
      s2_px     <= '0;
      s2_py     <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_byp <= bypass;
        s1_x   <= x_in;
        s1_y   <= y_in;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_byp <= s1_byp;
        s2_x   <= s1_x;
        s2_y   <= s1_y;
        s2_px  <= mul_x;
        s2_py  <= mul_y;
      end
      out_valid <= s2_valid;
      // Output registers keep their last sample while bubbles pass through.
      if (s2_valid) begin
        if (s2_byp) begin
          x_out <= s2_x;
          y_out <= s2_y;
          sat   <= 1'b0;
        end else begin
          x_out <= sc_x[DATA_WIDTH-1:0];
          y_out <= sc_y[DATA_WIDTH-1:0];
          sat   <= sc_x[DATA_WIDTH] | sc_y[DATA_WIDTH];
        end
      end
    end
  end

endmodule
